// File: rtl/player_input_pkg.sv
// Shared types and default timing constants for the player input block.
package player_input_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } chan_state_e;

  localparam int DB_TICKS_DEF     = 2;
  localparam int REPEAT_DELAY_DEF = 30;
  localparam int REPEAT_RATE_DEF  = 6;
  localparam int HOLD_W           = 8;

endpackage

// File: rtl/player_input_if.sv
// Pin bundle between the raw button inputs and the debounced game-side outputs.
interface player_input_if #(
  parameter int NUM_BTNS = 3
);
  // No handshake here: inputs are sampled every tick, level is held while the
  // button is accepted as down, press/release/repeat are one-tick strobes.
  logic [NUM_BTNS-1:0]   btn_raw_n_in;
  logic                  enable_in;
  logic [NUM_BTNS-1:0]   btn_level_out;
  logic [NUM_BTNS-1:0]   btn_press_out;
  logic [NUM_BTNS-1:0]   btn_release_out;
  logic [NUM_BTNS-1:0]   btn_repeat_out;
  logic [2*NUM_BTNS-1:0] state_dbg;

  modport master (
    output btn_raw_n_in, enable_in,
    input  btn_level_out, btn_press_out, btn_release_out, btn_repeat_out, state_dbg
  );

  modport slave (
    input  btn_raw_n_in, enable_in,
    output btn_level_out, btn_press_out, btn_release_out, btn_repeat_out, state_dbg
  );

endinterface

// File: rtl/input_channel_fsm.sv
// One button channel: synchroniser, debounce FSM and (with PLAYER_INPUT_REPEAT_EN)
// the hold counter that generates auto-repeat strobes.
module input_channel_fsm
  import player_input_pkg::*;
#(
  parameter int DB_TICKS     = DB_TICKS_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic       clk_60Hz_game,
  input  logic       reset,
  input  logic       btn_raw_n,
  input  logic       enable_in,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       repeat_o,
  output logic [1:0] state_dbg
);

  localparam int               CNT_W  = $clog2(DB_TICKS + 1);
  localparam logic [CNT_W-1:0] DB_C   = CNT_W'(DB_TICKS);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam bit               DB_ONE = (DB_TICKS == 1);

  if (DB_TICKS < 1 || DB_TICKS > 15) begin : g_bad_db
    $error("DB_TICKS out of range 1..15");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255) begin : g_bad_delay
    $error("REPEAT_DELAY out of range 1..255");
  end
  if (REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_rate
    $error("REPEAT_RATE out of range 1..255");
  end

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             en_q, en_d, run;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d, press_q, press_d, release_q, release_d;

  // en_q delays re-arming by one tick so a held button is re-debounced from scratch.
  assign run     = enable_in && en_q;
  assign cnt_inc = cnt_q + ONE_C;

  always_comb begin
    sync1_d   = ~btn_raw_n;
    sync2_d   = sync1_q;
    en_d      = enable_in;
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (!run) begin
      state_d = IDLE;
      cnt_d   = '0;
      level_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (sync2_q) begin
          if (DB_ONE) begin
            state_d = HELD;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            state_d = PRESS_CHK;
            cnt_d   = ONE_C;
          end
        end
        PRESS_CHK: if (sync2_q) begin
          if (cnt_inc == DB_C) begin
            state_d = HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        HELD: if (!sync2_q) begin
          if (DB_ONE) begin
            state_d   = IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = REL_CHK;
            cnt_d   = ONE_C;
          end
        end
        REL_CHK: if (!sync2_q) begin
          if (cnt_inc == DB_C) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = HELD;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_60Hz_game or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      en_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      en_q      <= en_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef PLAYER_INPUT_REPEAT_EN
  localparam logic [HOLD_W-1:0] DELAY_C = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] RATE_C  = HOLD_W'(REPEAT_RATE);

  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc, hold_target;
  logic              fired_q, fired_d, repeat_q, repeat_d;
  logic              enter_held, stay_held;

  // After the first repeat the counter restarts from zero against the faster rate,
  // so it never needs to count past REPEAT_DELAY.
  assign enter_held  = (state_d == HELD) && (state_q == IDLE || state_q == PRESS_CHK);
  assign stay_held   = (state_d == HELD) && (state_q == HELD);
  assign hold_inc    = hold_q + 8'd1;
  assign hold_target = fired_q ? RATE_C : DELAY_C;

  always_comb begin
    hold_d   = hold_q;
    fired_d  = fired_q;
    repeat_d = 1'b0;
    if (enter_held || state_d == IDLE) begin
      hold_d  = '0;
      fired_d = 1'b0;
    end else if (stay_held) begin
      if (hold_inc == hold_target) begin
        hold_d   = '0;
        fired_d  = 1'b1;
        repeat_d = 1'b1;
      end else begin
        hold_d = hold_inc;
      end
    end
  end

  always_ff @(posedge clk_60Hz_game or posedge reset) begin
    if (reset) begin
      hold_q   <= '0;
      fired_q  <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      fired_q  <= fired_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/player_input_processor.sv
// Debounced player buttons: NUM_BTNS independent channels. Define
// PLAYER_INPUT_REPEAT_EN to build in the auto-repeat strobes.
module player_input_processor
  import player_input_pkg::*;
#(
  parameter int NUM_BTNS     = 3,
  parameter int DB_TICKS     = DB_TICKS_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input logic           clk_60Hz_game,
  input logic           reset,
  player_input_if.slave pin
);

  logic [NUM_BTNS-1:0]   level_w, press_w, release_w, repeat_w;
  logic [2*NUM_BTNS-1:0] state_w;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    input_channel_fsm #(
      .DB_TICKS    (DB_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .clk_60Hz_game(clk_60Hz_game),
      .reset        (reset),
      .btn_raw_n    (pin.btn_raw_n_in[i]),
      .enable_in    (pin.enable_in),
      .level_o      (level_w[i]),
      .press_o      (press_w[i]),
      .release_o    (release_w[i]),
      .repeat_o     (repeat_w[i]),
      .state_dbg    (state_w[2*i +: 2])
    );
  end

  assign pin.btn_level_out   = level_w;
  assign pin.btn_press_out   = press_w;
  assign pin.btn_release_out = release_w;
  assign pin.btn_repeat_out  = repeat_w;
  assign pin.state_dbg       = state_w;

endmodule

// File: doc/player_input_processor.md
PLAYER_INPUT_PROCESSOR -- requirements
Module: player_input_processor

Interface
REQ-001 The block SHALL have parameter NUM_BTNS, default 3, giving the number of independent button channels.
REQ-002 The block SHALL have parameter DB_TICKS, default 2, giving the consecutive stable game ticks required to accept a level change (legal range 1..15).
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 30, giving the held ticks before the first auto-repeat pulse (legal range 1..255).
REQ-004 The block SHALL have parameter REPEAT_RATE, default 6, giving the ticks between later auto-repeat pulses (legal range 1..255).
REQ-005 clk_60Hz_game  input  1  game logic clock; all state SHALL be clocked on its rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 btn_raw_n_in  input  NUM_BTNS  raw button pins, active-low, asynchronous to the clock.
REQ-008 enable_in  input  1  active-high channel enable; low masks all outputs.
REQ-009 btn_level_out  output  NUM_BTNS  debounced held level per channel, active-high.
REQ-010 btn_press_out  output  NUM_BTNS  one-tick pulse on accepted press.
REQ-011 btn_release_out  output  NUM_BTNS  one-tick pulse on accepted release.
REQ-012 btn_repeat_out  output  NUM_BTNS  one-tick auto-repeat pulse while held.

Function
REQ-013 Each channel SHALL invert its raw bit and pass it through a two-flop synchroniser; only the second stage SHALL feed the channel FSM.
REQ-014 Each channel FSM SHALL have states IDLE, PRESS_CHK, HELD and REL_CHK, plus a stability counter of width clog2(DB_TICKS+1).
REQ-015 In IDLE, a synced 1 SHALL move to PRESS_CHK with count=1; if DB_TICKS=1 it SHALL move directly to HELD.
REQ-016 In PRESS_CHK, a synced 1 SHALL increment the count and enter HELD when count reaches DB_TICKS; a synced 0 SHALL return to IDLE with count cleared.
REQ-017 On entry to HELD the block SHALL drive btn_level_out=1 and btn_press_out=1 for exactly that tick.
REQ-018 HELD/REL_CHK SHALL mirror the press path: DB_TICKS consecutive synced 0 SHALL enter IDLE with btn_level_out=0 and btn_release_out=1 for one tick, and a synced 1 in REL_CHK SHALL return to HELD with no pulse.
REQ-019 Latency from a clean raw transition to the output change SHALL be exactly DB_TICKS+2 rising edges.
REQ-020 The hold counter SHALL clear on entry to HELD from PRESS_CHK, increment each tick in HELD, and freeze in REL_CHK.
REQ-021 btn_repeat_out SHALL pulse when the hold counter reaches REPEAT_DELAY and every REPEAT_RATE ticks thereafter, and the counter SHALL reload to avoid wrap-around.
REQ-022 btn_press_out, btn_release_out and btn_repeat_out SHALL never be high in the same tick on the same channel.
REQ-023 Channels SHALL be fully independent, so simultaneous events on several channels SHALL each produce their own outputs in the same tick.
REQ-024 While enable_in=0, all outputs SHALL be 0 and every FSM SHALL be forced to IDLE with counters cleared; the synchronisers SHALL keep running.
REQ-025 After enable_in rises, a button still held SHALL be re-debounced and produce a fresh press pulse DB_TICKS+1 ticks later.

Reset
REQ-026 Reset SHALL asynchronously clear the synchronisers, FSMs (to IDLE), counters and all outputs to 0.
REQ-027 Reset asserted mid-press or mid-hold SHALL produce no release pulse, either at assertion or at deassertion.

Configuration
REQ-028 When macro PLAYER_INPUT_REPEAT_EN is defined, the hold counter and btn_repeat_out behaviour of REQ-020/021 SHALL be compiled in.
REQ-029 When PLAYER_INPUT_REPEAT_EN is undefined, the hold counters SHALL be absent, btn_repeat_out SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Package player_input_pkg SHALL hold the channel state enum (IDLE, PRESS_CHK, HELD, REL_CHK) and the default constants for DB_TICKS, REPEAT_DELAY and REPEAT_RATE.
REQ-031 The per-channel synchroniser, FSM and counters SHALL live in sub-module input_channel_fsm, instantiated NUM_BTNS times by a generate loop.

Verification
REQ-032 The bench SHALL check reset: reset=1 with all buttons pressed -> all outputs 0; after release of reset -> btn_level_out rises at edge 4, press pulse only.
REQ-033 The bench SHALL check a clean press (defaults): raw[0] low at t0 -> btn_level_out[0]=1 and btn_press_out[0]=1 at edge 4, btn_press_out[0]=0 at edge 5; release -> btn_release_out[0] one tick at edge 4 after release.
REQ-034 The bench SHALL check glitch rejection: raw[1] low for exactly one tick -> no press, level or release activity on channel 1.
REQ-035 The bench SHALL check auto-repeat: raw[2] held 60 ticks -> repeat pulses at HELD ticks 30, 36, 42, 48, 54; with the macro undefined -> no repeat pulses.
REQ-036 The bench SHALL check enable masking: channel 0 held, enable_in=0 for 5 ticks -> outputs 0 with no release pulse; enable_in=1 -> press pulse 3 ticks later.
REQ-037 The bench SHALL check simultaneous events: channels 0 and 1 pressed in the same tick -> both press pulses at the same edge, with a one-tick glitch on channel 2 ignored.
